// File: rtl/lnext_responder_pkg.sv
// Shared types for the L_NEXT responder: command and state encodings plus the cache-wide bool_t.
package cachePkg;

    typedef logic bool_t;

    localparam int LNEXT_CMD_W = 2;

    typedef enum logic [LNEXT_CMD_W-1:0] {
        NOP       = 2'd0,
        READ_OUT  = 2'd1,
        WRITE_OUT = 2'd2
    } lnext_cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        BURST    = 2'd2,
        WCOLLECT = 2'd3
    } lnext_state_t;

endpackage

// File: rtl/lnext_linestore.sv
// Backing store for the L_NEXT model: MEMLINES lines of LINEITEMS words, a per-line written bit,
// one synchronous full-line write port and one combinational word read port.
module lnext_linestore
    import cachePkg::*;
#(
    parameter int LINEITEMS = 64,
    parameter int WORDBITS  = 32,
    parameter int MEMLINES  = 256
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  bool_t                                wr_en,
    input  logic [$clog2(MEMLINES)-1:0]          wr_index,
    input  logic [LINEITEMS-1:0][WORDBITS-1:0]   wr_line,
    input  logic [$clog2(MEMLINES)-1:0]          rd_index,
    input  logic [$clog2(LINEITEMS)-1:0]         rd_k,
    output logic [WORDBITS-1:0]                  rd_word,
    output bool_t                                rd_written
);

    logic [LINEITEMS-1:0][WORDBITS-1:0] mem_q [MEMLINES];
    logic [MEMLINES-1:0]                written_q;
    logic [MEMLINES-1:0]                written_d;

    always_comb begin
        written_d = written_q;
        if (wr_en) begin
            written_d[wr_index] = 1'b1;
        end
    end

    // Line contents are deliberately left unreset; only the written bits define validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_index] <= wr_line;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    assign rd_word    = mem_q[rd_index][rd_k];
    assign rd_written = written_q[rd_index];

endmodule

// File: rtl/lnext_responder.sv
// L_NEXT memory model: READ_OUT returns a line as a latency-delayed word burst, WRITE_OUT collects a line.
// Optional LNEXT_STATS_EN adds read_count/write_count ports counting accepted commands.
module lnext_responder
    import cachePkg::*;
#(
    parameter int LINEITEMS    = 64,
    parameter int WORDBITS     = 32,
    parameter int LINEADDRBITS = 26,
    parameter int MEMLINES     = 256,
    parameter int LATENCY      = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  lnext_cmd_t              cmd_in,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LINEADDRBITS-1:0] add_in,
    input  logic [WORDBITS-1:0]     wdata,
    input  logic                    wdata_valid,
    output logic [WORDBITS-1:0]     rdata,
    output logic                    rdata_valid,
    output logic                    rdata_last,
    output logic                    busy
`ifdef LNEXT_STATS_EN
    ,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
`endif
);

    localparam int KW = $clog2(LINEITEMS);
    localparam int IW = $clog2(MEMLINES);
    localparam int PW = LINEADDRBITS + KW;

    lnext_state_t                       state_q, state_d;
    logic [KW-1:0]                      k_q, k_d;
    logic [31:0]                        lat_q, lat_d;
    logic [LINEADDRBITS-1:0]            addr_q, addr_d;
    logic [WORDBITS-1:0]                rdata_q, rdata_d;
    bool_t                              rdata_valid_q, rdata_valid_d;
    bool_t                              rdata_last_q, rdata_last_d;
    logic [LINEITEMS-1:0][WORDBITS-1:0] wbuf_q, wbuf_d;

    bool_t                              accept;
    bool_t                              wr_en;
    logic [LINEITEMS-1:0][WORDBITS-1:0] wr_line;
    logic [WORDBITS-1:0]                rd_word;
    bool_t                              rd_written;
    logic [PW-1:0]                      pattern;
    logic [WORDBITS-1:0]                pattern_word;

    assign pattern = {addr_q, k_q};

    generate
        if (PW >= WORDBITS) begin : g_pat_trunc
            assign pattern_word = pattern[WORDBITS-1:0];
        end else begin : g_pat_ext
            assign pattern_word = {{(WORDBITS-PW){1'b0}}, pattern};
        end
    endgenerate

    lnext_linestore #(
        .LINEITEMS (LINEITEMS),
        .WORDBITS  (WORDBITS),
        .MEMLINES  (MEMLINES)
    ) u_linestore (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_index   (addr_q[IW-1:0]),
        .wr_line    (wr_line),
        .rd_index   (addr_q[IW-1:0]),
        .rd_k       (k_q),
        .rd_word    (rd_word),
        .rd_written (rd_written)
    );

    assign accept = cmd_valid && (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        lat_d         = lat_q;
        addr_d        = addr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        rdata_last_d  = 1'b0;
        wbuf_d        = wbuf_q;
        wr_en         = 1'b0;
        // The final word bypasses the buffer so the line commits on the edge that delivers it.
        wr_line                = wbuf_q;
        wr_line[LINEITEMS-1]   = wdata;

        case (state_q)
            IDLE: begin
                if (accept && cmd_in == READ_OUT) begin
                    addr_d  = add_in;
                    k_d     = '0;
                    lat_d   = '0;
                    state_d = (LATENCY == 0) ? BURST : WAIT;
                end else if (accept && cmd_in == WRITE_OUT) begin
                    addr_d  = add_in;
                    k_d     = '0;
                    state_d = WCOLLECT;
                end
            end
            WAIT: begin
                if (lat_q == 32'(LATENCY - 1)) begin
                    state_d = BURST;
                end else begin
                    lat_d = lat_q + 32'd1;
                end
            end
            BURST: begin
                rdata_d       = rd_written ? rd_word : pattern_word;
                rdata_valid_d = 1'b1;
                rdata_last_d  = (k_q == '1);
                k_d           = k_q + 1'b1;
                if (k_q == '1) begin
                    state_d = IDLE;
                end
            end
            WCOLLECT: begin
                if (wdata_valid) begin
                    wbuf_d[k_q] = wdata;
                    k_d         = k_q + 1'b1;
                    if (k_q == '1) begin
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            lat_q         <= '0;
            addr_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            lat_q         <= lat_d;
            addr_q        <= addr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    always_ff @(posedge clock) begin
        wbuf_q <= wbuf_d;
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;

`ifdef LNEXT_STATS_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (accept && cmd_in == READ_OUT) begin
            read_count_d = read_count_q + 32'd1;
        end
        if (accept && cmd_in == WRITE_OUT) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_lnext_responder.sv
// Directed self-checking bench for lnext_responder with default parameters (LATENCY=4, 64-word lines).
module tb_lnext_responder;
    import cachePkg::*;

    logic        clock;
    logic        reset_n;
    lnext_cmd_t  cmd_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [25:0] add_in;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        busy;
`ifdef LNEXT_STATS_EN
    logic [31:0] read_count;
    logic [31:0] write_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] got_words [64];
    int          got_lat;
    int          got_last_pos;
    int          got_gaps;
    logic        got_end_valid;
    int          busy_cycles;

    lnext_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_in      (cmd_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .add_in      (add_in),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_last  (rdata_last),
        .busy        (busy)
`ifdef LNEXT_STATS_EN
        ,
        .read_count  (read_count),
        .write_count (write_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic read_line(input logic [25:0] a);
        cmd_in    = READ_OUT;
        add_in    = a;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_in    = NOP;
        got_lat   = 0;
        while (!rdata_valid && got_lat < 40) begin
            tick();
            got_lat++;
        end
        got_last_pos = -1;
        got_gaps     = 0;
        for (int j = 0; j < 64; j++) begin
            got_words[j] = rdata;
            if (!rdata_valid) got_gaps++;
            if (rdata_last && got_last_pos < 0) got_last_pos = j;
            tick();
        end
        got_end_valid = rdata_valid;
    endtask

    task automatic write_line(input logic [25:0] a, input logic [31:0] base, input bit alt);
        cmd_in    = WRITE_OUT;
        add_in    = a;
        cmd_valid = 1'b1;
        tick();
        cmd_valid   = 1'b0;
        cmd_in      = NOP;
        busy_cycles = 0;
        for (int j = 0; j < 64; j++) begin
            if (alt) begin
                wdata_valid = 1'b0;
                wdata       = 32'hDEAD_0000 | 32'(j);
                if (busy) busy_cycles++;
                tick();
            end
            wdata       = base + 32'(j);
            wdata_valid = 1'b1;
            if (busy) busy_cycles++;
            tick();
        end
        wdata_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        compared++;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        compared++;
        if (rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        compared++;
        if (rdata_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rdata_valid: got %b expected 0", rdata_valid); end
        compared++;
        if (rdata_last !== 1'b0) begin mismatched++; $display("FAIL reset_rdata_last: got %b expected 0", rdata_last); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_read_pattern;
        read_line(26'h0000010);
        compared++;
        if (got_lat !== 5) begin mismatched++; $display("FAIL read_latency: got %0d expected 5", got_lat); end
        compared++;
        if (got_gaps !== 0) begin mismatched++; $display("FAIL read_gaps: got %0d expected 0", got_gaps); end
        compared++;
        if (got_last_pos !== 63) begin mismatched++; $display("FAIL read_last_pos: got %0d expected 63", got_last_pos); end
        for (int j = 0; j < 64; j++) begin
            compared++;
            if (got_words[j] !== 32'h0000_0400 + 32'(j)) begin
                mismatched++;
                $display("FAIL read_pattern[%0d]: got %h expected %h", j, got_words[j], 32'h0000_0400 + 32'(j));
            end
        end
        compared++;
        if (got_end_valid !== 1'b0) begin mismatched++; $display("FAIL read_end_valid: got %b expected 0", got_end_valid); end
        compared++;
        if (rdata !== 32'h0000_043F) begin mismatched++; $display("FAIL read_hold: got %h expected 0000043f", rdata); end
    endtask

    task automatic test_write_read;
        write_line(26'h3, 32'hA000_0000, 1'b0);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL write_done_busy: got %b expected 0", busy); end
        compared++;
        if (busy_cycles !== 64) begin mismatched++; $display("FAIL write_busy_cycles: got %0d expected 64", busy_cycles); end
        read_line(26'h3);
        for (int j = 0; j < 64; j++) begin
            compared++;
            if (got_words[j] !== 32'hA000_0000 + 32'(j)) begin
                mismatched++;
                $display("FAIL write_read[%0d]: got %h expected %h", j, got_words[j], 32'hA000_0000 + 32'(j));
            end
        end
    endtask

    task automatic test_alias;
        // 0x103 mod 256 == 0x3, so it sees the line written above; 0x4 is a fresh line.
        read_line(26'h103);
        compared++;
        if (got_words[0] !== 32'hA000_0000) begin mismatched++; $display("FAIL alias_first: got %h expected a0000000", got_words[0]); end
        compared++;
        if (got_words[63] !== 32'hA000_003F) begin mismatched++; $display("FAIL alias_last: got %h expected a000003f", got_words[63]); end
        read_line(26'h4);
        compared++;
        if (got_words[0] !== 32'h0000_0100) begin mismatched++; $display("FAIL unwritten_first: got %h expected 00000100", got_words[0]); end
    endtask

    task automatic test_back_to_back;
        int n;
        int ready_bad;
        int beats;
        int bad_data;
        cmd_in    = READ_OUT;
        add_in    = 26'h20;
        cmd_valid = 1'b1;
        tick();
        add_in    = 26'h21;
        n         = 0;
        ready_bad = 0;
        beats     = 0;
        bad_data  = 0;
        while (!rdata_last && n < 100) begin
            if (cmd_ready) ready_bad++;
            if (rdata_valid) begin
                if (rdata !== 32'h0000_0800 + 32'(beats)) bad_data++;
                beats++;
            end
            tick();
            n++;
        end
        compared++;
        if (ready_bad !== 0) begin mismatched++; $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", ready_bad); end
        compared++;
        if (bad_data !== 0) begin mismatched++; $display("FAIL b2b_first_data: got %0d bad beats expected 0", bad_data); end
        compared++;
        if (beats + 1 !== 64) begin mismatched++; $display("FAIL b2b_beats: got %0d expected 64", beats + 1); end
        compared++;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_at_last: got %b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        cmd_in    = NOP;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_second_accept: got busy %b expected 1", busy); end
        n = 0;
        while (!rdata_valid && n < 40) begin
            tick();
            n++;
        end
        compared++;
        if (n !== 5) begin mismatched++; $display("FAIL b2b_second_latency: got %0d expected 5", n); end
        compared++;
        if (rdata !== 32'h0000_0840) begin mismatched++; $display("FAIL b2b_second_data: got %h expected 00000840", rdata); end
        n = 0;
        while ((busy || rdata_valid) && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_stall_write;
        write_line(26'h5, 32'hB000_0000, 1'b1);
        compared++;
        if (busy_cycles !== 128) begin mismatched++; $display("FAIL stall_busy_cycles: got %0d expected 128", busy_cycles); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL stall_done_busy: got %b expected 0", busy); end
        read_line(26'h5);
        for (int j = 0; j < 64; j++) begin
            compared++;
            if (got_words[j] !== 32'hB000_0000 + 32'(j)) begin
                mismatched++;
                $display("FAIL stall_read[%0d]: got %h expected %h", j, got_words[j], 32'hB000_0000 + 32'(j));
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        cmd_in    = READ_OUT;
        add_in    = 26'h7;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_in    = NOP;
        n = 0;
        while (!rdata_valid && n < 40) begin
            tick();
            n++;
        end
        repeat (10) tick();
        compared++;
        if (rdata !== 32'h0000_01CA) begin mismatched++; $display("FAIL mid_beat10: got %h expected 000001ca", rdata); end
        reset_n = 1'b0;
        tick();
        compared++;
        if (rdata_valid !== 1'b0) begin mismatched++; $display("FAIL mid_reset_valid: got %b expected 0", rdata_valid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
        tick();
        cmd_in    = WRITE_OUT;
        add_in    = 26'h9;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_in    = NOP;
        for (int j = 0; j < 20; j++) begin
            wdata       = 32'hC000_0000 + 32'(j);
            wdata_valid = 1'b1;
            tick();
        end
        wdata_valid = 1'b0;
        reset_n     = 1'b0;
        tick();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL partial_reset_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
        tick();
        read_line(26'h9);
        for (int j = 0; j < 64; j++) begin
            compared++;
            if (got_words[j] !== 32'h0000_0240 + 32'(j)) begin
                mismatched++;
                $display("FAIL partial_read[%0d]: got %h expected %h", j, got_words[j], 32'h0000_0240 + 32'(j));
            end
        end
    endtask

`ifdef LNEXT_STATS_EN
    task automatic test_stats;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        read_line(26'h1);
        write_line(26'h2, 32'h1111_0000, 1'b0);
        read_line(26'h2);
        write_line(26'h6, 32'h2222_0000, 1'b0);
        read_line(26'h6);
        compared++;
        if (read_count !== 32'd3) begin mismatched++; $display("FAIL stats_reads: got %0d expected 3", read_count); end
        compared++;
        if (write_count !== 32'd2) begin mismatched++; $display("FAIL stats_writes: got %0d expected 2", write_count); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        compared++;
        if (read_count !== 32'd0) begin mismatched++; $display("FAIL stats_reads_reset: got %0d expected 0", read_count); end
        compared++;
        if (write_count !== 32'd0) begin mismatched++; $display("FAIL stats_writes_reset: got %0d expected 0", write_count); end
        tick();
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        cmd_in      = NOP;
        cmd_valid   = 1'b0;
        add_in      = '0;
        wdata       = '0;
        wdata_valid = 1'b0;
        test_reset();
        test_read_pattern();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_stall_write();
        test_reset_mid();
`ifdef LNEXT_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
